op_sequencer: RTL and testbench

//  Decode-stage sequencer in front of the control unit. Turns fetched opcodes into the control unit's opCode/makeMeBubble inputs.

---
 rtl/op_sequencer_pkg.sv | 30 +++
 rtl/op_sequencer_bubble_counter.sv | 25 ++
 rtl/op_sequencer.sv | 161 ++++++++++++++++
 tb/tb_op_sequencer.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/op_sequencer_pkg.sv
// Shared opcode constants and sequencer state encoding for the decode-stage op_sequencer.
package op_sequencer_pkg;

    localparam logic [4:0] OP_NOP   = 5'b00000;
    localparam logic [4:0] OP_CALL  = 5'b11000;
    localparam logic [4:0] OP_CALL2 = 5'b11001;
    localparam logic [4:0] OP_RET   = 5'b11010;
    localparam logic [4:0] OP_RET2  = 5'b11011;
    localparam logic [4:0] OP_RTI   = 5'b11100;
    localparam logic [4:0] OP_RTI2  = 5'b11101;
    localparam logic [4:0] OP_INT1  = 5'b11110;
    localparam logic [4:0] OP_INT2  = 5'b11111;

    typedef enum logic [2:0] {
        S_NORMAL = 3'd0,
        S_CALL2  = 3'd1,
        S_RET2   = 3'd2,
        S_RTI2   = 3'd3,
        S_INT1   = 3'd4,
        S_INT2   = 3'd5,
        S_DRAIN  = 3'd6
    } seqState_t;

    // Second halves and interrupt opcodes are generated internally only; fetching one is illegal.
    function automatic logic isReservedOp(input logic [4:0] op);
        return (op == OP_CALL2) || (op == OP_RET2) || (op == OP_RTI2) ||
               (op == OP_INT1)  || (op == OP_INT2);
    endfunction

endpackage

// File: rtl/op_sequencer_bubble_counter.sv
// 3-bit loadable down counter that times the post-return drain bubbles.
module op_sequencer_bubble_counter (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [2:0] loadVal,
    input  logic       dec,
    output logic       zero
);

    logic [2:0] cntReg;

    always_ff @(posedge clk) begin
        if (rst) begin
            cntReg <= 3'd0;
        end else if (load) begin
            cntReg <= loadVal;
        end else if (dec && (cntReg != 3'd0)) begin
            cntReg <= cntReg - 3'd1;
        end
    end

    assign zero = (cntReg == 3'd0);

endmodule

// File: rtl/op_sequencer.sv
// Decode-stage sequencer: expands CALL/RET/RTI, injects the interrupt pair and inserts bubbles.
// Optional OP_SEQ_ISR_BLOCK_EN: blocks interrupt nesting between INT2 and RTI2.
module op_sequencer
    import op_sequencer_pkg::*;
#(
    parameter int OPW         = 5,
    parameter int RET_BUBBLES = 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [OPW-1:0] in_op,
    input  logic           in_valid,
    input  logic           stall,
    input  logic           flush,
    input  logic           irq,
    output logic [OPW-1:0] opCode,
    output logic           makeMeBubble,
    output logic           pc_hold,
    output logic           int_ack
);

    // Counter is loaded with one less than the bubble count; DRAIN exits on the zero cycle.
    localparam logic [2:0] DRAIN_LOAD = (RET_BUBBLES > 0) ? 3'(RET_BUBBLES - 1) : 3'd0;

    seqState_t      stateReg, stateNext;
    logic [OPW-1:0] opCodeNext;
    logic           bubbleNext, pcHoldNext, intAckNext;
    logic           irqPendReg, irqPendNext;
    logic           int1Issue, irqAllowed;
    logic           cntLoad, cntDec, cntZero;

`ifdef OP_SEQ_ISR_BLOCK_EN
    logic inIsrReg, inIsrNext;
    assign irqAllowed = !inIsrReg;
`else
    assign irqAllowed = 1'b1;
`endif

    op_sequencer_bubble_counter uDrain (
        .clk     (clk),
        .rst     (rst),
        .load    (cntLoad),
        .loadVal (DRAIN_LOAD),
        .dec     (cntDec),
        .zero    (cntZero)
    );

    always_comb begin
        stateNext  = stateReg;
        opCodeNext = OPW'(OP_NOP);
        bubbleNext = 1'b1;
        pcHoldNext = 1'b0;
        intAckNext = 1'b0;
        cntLoad    = 1'b0;
        cntDec     = 1'b0;
        int1Issue  = 1'b0;
`ifdef OP_SEQ_ISR_BLOCK_EN
        inIsrNext  = inIsrReg;
`endif
        case (stateReg)
            S_NORMAL: begin
                if (flush) begin
                    pcHoldNext = 1'b0;
                end else if (stall) begin
                    pcHoldNext = 1'b1;
                end else if (irqPendReg && irqAllowed) begin
                    // Bubble and hold PC so the fetched instruction is refetched after the ISR entry.
                    pcHoldNext = 1'b1;
                    stateNext  = S_INT1;
                end else if (!in_valid) begin
                    pcHoldNext = 1'b0;
                end else if ((in_op == OPW'(OP_CALL)) || (in_op == OPW'(OP_RET)) ||
                             (in_op == OPW'(OP_RTI))) begin
                    opCodeNext = in_op;
                    bubbleNext = 1'b0;
                    pcHoldNext = 1'b1;
                    if (in_op == OPW'(OP_CALL))
                        stateNext = S_CALL2;
                    else if (in_op == OPW'(OP_RET))
                        stateNext = S_RET2;
                    else
                        stateNext = S_RTI2;
                end else if (!isReservedOp(5'(in_op))) begin
                    opCodeNext = in_op;
                    bubbleNext = 1'b0;
                end
            end
            S_CALL2: begin
                opCodeNext = OPW'(OP_CALL2);
                bubbleNext = 1'b0;
                stateNext  = S_NORMAL;
            end
            S_RET2, S_RTI2: begin
                opCodeNext = (stateReg == S_RET2) ? OPW'(OP_RET2) : OPW'(OP_RTI2);
                bubbleNext = 1'b0;
`ifdef OP_SEQ_ISR_BLOCK_EN
                if (stateReg == S_RTI2)
                    inIsrNext = 1'b0;
`endif
                if (RET_BUBBLES == 0) begin
                    stateNext = S_NORMAL;
                end else begin
                    cntLoad   = 1'b1;
                    stateNext = S_DRAIN;
                end
            end
            S_INT1: begin
                opCodeNext = OPW'(OP_INT1);
                bubbleNext = 1'b0;
                pcHoldNext = 1'b1;
                intAckNext = 1'b1;
                int1Issue  = 1'b1;
                stateNext  = S_INT2;
            end
            S_INT2: begin
                opCodeNext = OPW'(OP_INT2);
                bubbleNext = 1'b0;
                pcHoldNext = 1'b1;
`ifdef OP_SEQ_ISR_BLOCK_EN
                inIsrNext  = 1'b1;
`endif
                stateNext  = S_NORMAL;
            end
            S_DRAIN: begin
                pcHoldNext = 1'b1;
                if (cntZero)
                    stateNext = S_NORMAL;
                else
                    cntDec = 1'b1;
            end
            default: stateNext = S_NORMAL;
        endcase
        // A new request in the same cycle as INT1 issue survives the clear.
        irqPendNext = irq | (irqPendReg & ~int1Issue);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stateReg     <= S_NORMAL;
            opCode       <= OPW'(OP_NOP);
            makeMeBubble <= 1'b1;
            pc_hold      <= 1'b0;
            int_ack      <= 1'b0;
            irqPendReg   <= 1'b0;
`ifdef OP_SEQ_ISR_BLOCK_EN
            inIsrReg     <= 1'b0;
`endif
        end else begin
            stateReg     <= stateNext;
            opCode       <= opCodeNext;
            makeMeBubble <= bubbleNext;
            pc_hold      <= pcHoldNext;
            int_ack      <= intAckNext;
            irqPendReg   <= irqPendNext;
`ifdef OP_SEQ_ISR_BLOCK_EN
            inIsrReg     <= inIsrNext;
`endif
        end
    end

endmodule

// File: tb/tb_op_sequencer.sv
// Scoreboard bench for op_sequencer: a micro-op queue model predicts each cycle's registered outputs.
module tb_op_sequencer;

    localparam int RB = 2;

    localparam logic [4:0] NOP  = 5'b00000;
    localparam logic [4:0] CALL = 5'b11000;
    localparam logic [4:0] RET  = 5'b11010;
    localparam logic [4:0] RTI  = 5'b11100;
    localparam logic [4:0] INT1 = 5'b11110;
    localparam logic [4:0] INT2 = 5'b11111;
    localparam logic [4:0] RTI2 = 5'b11101;

    typedef struct packed {
        logic [4:0] op;
        logic       bub;
        logic       hold;
        logic       ack;
    } out_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] in_op = 5'd0;
    logic       in_valid = 1'b0;
    logic       stall = 1'b0;
    logic       flush = 1'b0;
    logic       irq = 1'b0;
    logic [4:0] opCode;
    logic       makeMeBubble, pc_hold, int_ack;

    out_t expQ[$];
    int   phQ[$];
    out_t seqQ[$];
    logic pend = 1'b0;
    logic isr = 1'b0;
    int   phase = 0;
    int   nTests = 0;
    int   nFail = 0;

    always #5 clk = ~clk;

    op_sequencer #(.OPW(5), .RET_BUBBLES(RB)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_op        (in_op),
        .in_valid     (in_valid),
        .stall        (stall),
        .flush        (flush),
        .irq          (irq),
        .opCode       (opCode),
        .makeMeBubble (makeMeBubble),
        .pc_hold      (pc_hold),
        .int_ack      (int_ack)
    );

    // Expected output appearing after the coming clock edge, from the current inputs.
    task automatic model_cycle();
        out_t e;
        logic blk;
        logic int1Pop;
        e = {NOP, 1'b1, 1'b0, 1'b0};
        int1Pop = 1'b0;
`ifdef OP_SEQ_ISR_BLOCK_EN
        blk = isr;
`else
        blk = 1'b0;
`endif
        if (rst) begin
            seqQ.delete();
            pend = 1'b0;
            isr  = 1'b0;
        end else if (seqQ.size() > 0) begin
            e = seqQ.pop_front();
            if (e.op == INT1) int1Pop = 1'b1;
            if (e.op == INT2) isr = 1'b1;
            if (e.op == RTI2) isr = 1'b0;
        end else if (flush) begin
            e.hold = 1'b0;
        end else if (stall) begin
            e.hold = 1'b1;
        end else if (pend && !blk) begin
            e.hold = 1'b1;
            seqQ.push_back({INT1, 1'b0, 1'b1, 1'b1});
            seqQ.push_back({INT2, 1'b0, 1'b1, 1'b0});
        end else if (!in_valid) begin
            e.hold = 1'b0;
        end else if (in_op == CALL || in_op == RET || in_op == RTI) begin
            e = {in_op, 1'b0, 1'b1, 1'b0};
            seqQ.push_back({5'(in_op + 5'd1), 1'b0, 1'b0, 1'b0});
            if (in_op != CALL)
                for (int i = 0; i < RB; i++) seqQ.push_back({NOP, 1'b1, 1'b1, 1'b0});
        end else if (in_op == 5'b11001 || in_op == 5'b11011 || in_op == 5'b11101 ||
                     in_op == 5'b11110 || in_op == 5'b11111) begin
            e.hold = 1'b0;
        end else begin
            e = {in_op, 1'b0, 1'b0, 1'b0};
        end
        if (!rst) pend = int1Pop ? irq : (pend | irq);
        expQ.push_back(e);
        phQ.push_back(phase);
    endtask

    task automatic step(input logic r, input logic [4:0] op, input logic v,
                        input logic st, input logic fl, input logic iq);
        @(negedge clk);
        rst = r; in_op = op; in_valid = v; stall = st; flush = fl; irq = iq;
        model_cycle();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 5'b00001, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    // Monitor: the DUT presents a registered output every cycle; compare just after the edge.
    initial begin
        out_t e;
        int   ph;
        forever begin
            @(posedge clk);
            #1;
            if (expQ.size() > 0) begin
                e  = expQ.pop_front();
                ph = phQ.pop_front();
                nTests++;
                if ({opCode, makeMeBubble, pc_hold, int_ack} !== e) begin
                    nFail++;
                    $display("FAIL out phase=%0d t=%0t got op=%b bub=%b hold=%b ack=%b exp op=%b bub=%b hold=%b ack=%b",
                             ph, $time, opCode, makeMeBubble, pc_hold, int_ack, e.op, e.bub, e.hold, e.ack);
                end
            end
        end
    end

    initial begin
        // Reset, then reset held 2 cycles in the middle of CALL.
        phase = 1;
        step(1'b1, NOP, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, NOP, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, CALL, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, NOP, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, NOP, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, NOP, 1'b0, 1'b0, 1'b0, 1'b0);
        // Plain op, then CALL expansion.
        phase = 2;
        step(1'b0, 5'b01001, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, CALL, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(2);
        // RET with drain bubbles.
        phase = 3;
        step(1'b0, RET, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, NOP, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(4);
        // irq pulse during RET2.
        phase = 4;
        step(1'b0, RET, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 5'b00011, 1'b1, 1'b0, 1'b0, 1'b1);
        idle(7);
        // stall+flush together, stall during CALL2, illegal raw opcode.
        phase = 5;
        step(1'b0, 5'b00101, 1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b0, 5'b00101, 1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b0, CALL, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 5'b00101, 1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b0, 5'b11011, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(1);
        // Second irq while inside the ISR, then RTI.
        phase = 6;
        step(1'b0, 5'b00001, 1'b1, 1'b0, 1'b0, 1'b1);
        idle(4);
        step(1'b0, 5'b00001, 1'b1, 1'b0, 1'b0, 1'b1);
        idle(5);
        step(1'b0, RTI, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(8);
        // Randomized traffic.
        phase = 7;
        for (int n = 0; n < 3000; n++) begin
            logic [4:0] op;
            int sel;
            sel = $urandom_range(0, 7);
            if (sel == 0)      op = CALL;
            else if (sel == 1) op = RET;
            else if (sel == 2) op = RTI;
            else               op = 5'($urandom_range(0, 31));
            step(($urandom_range(0, 199) == 0), op, ($urandom_range(0, 7) != 0),
                 ($urandom_range(0, 9) == 0), ($urandom_range(0, 11) == 0),
                 ($urandom_range(0, 19) == 0));
        end
        phase = 8;
        idle(10);
        @(negedge clk);
        @(negedge clk);
        nTests++;
        if (expQ.size() != 0) begin
            nFail++;
            $display("FAIL drain left=%0d need 0", expQ.size());
        end
        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
